// File: rtl/ex_mem_skid_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_skid_reg
//
// EX->MEM pipeline register built as a 2-entry skid buffer. A valid/ready
// handshake on both sides lets MEM apply back-pressure without losing an
// instruction. A flush input squashes everything held (branch squash).
//
// The main entry drives every output straight from flops. The skid entry
// absorbs the single instruction that EX can push in the cycle where
// in_ready is still high but MEM has stalled. There is no combinational path
// from any input to any output.
//
// Optional feature macro: PIPE_STAT_EN
//   When defined, adds the stall_cnt output. It is a saturating count of
//   cycles with out_valid=1 and out_ready=0. Only reset clears it; flush
//   does not.
//
// Parameters:
//   DATA_W  width of alu_result / st_val
//   DEST_W  width of destination register index
//   CNT_W   width of stall_cnt (PIPE_STAT_EN only)
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   flush          synchronous squash of all held entries (wins over xfers)
//   in_valid       EX presents an instruction
//   in_ready       buffer can accept (registered)
//   wb_en_in, mem_r_en_in, mem_w_en_in, dest_in, alu_result_in, st_val_in
//                  EX payload
//   out_valid      MEM side holds a valid instruction
//   out_ready      MEM accepts this cycle
//   wb_en_out, mem_r_en_out, mem_w_en_out, dest_out, alu_result_out,
//   st_val_out     MEM payload (control bits are 0 whenever out_valid=0)
//   occupancy      entries held: 0, 1 or 2
//   stall_cnt      back-pressure cycle counter (PIPE_STAT_EN only)
// ---------------------------------------------------------------------------
module ex_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] st_val_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] st_val_out,
  output logic [1:0]        occupancy
`ifdef PIPE_STAT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Handshake status flops; each is a pure function of the state, but it is
  // registered so that in_ready / out_valid / occupancy leave from flops.
  logic       r_in_ready;
  logic       r_out_valid;
  logic [1:0] r_occ;

  logic       w_in_ready_next;
  logic       w_out_valid_next;
  logic [1:0] w_occ_next;

  // Main entry (drives outputs)
  logic              r_main_wb;
  logic              r_main_mr;
  logic              r_main_mw;
  logic [DEST_W-1:0] r_main_dest;
  logic [DATA_W-1:0] r_main_alu;
  logic [DATA_W-1:0] r_main_st;

  // Skid entry
  logic              r_skid_wb;
  logic              r_skid_mr;
  logic              r_skid_mw;
  logic [DEST_W-1:0] r_skid_dest;
  logic [DATA_W-1:0] r_skid_alu;
  logic [DATA_W-1:0] r_skid_st;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;
  logic w_clr_main_ctrl;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= w_in_ready_next;
      r_out_valid <= w_out_valid_next;
      r_occ       <= w_occ_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_in_xfer) w_state_next = S_FULL;
        S_FULL: begin
          if (w_in_xfer && !w_out_xfer)      w_state_next = S_SKID;
          else if (!w_in_xfer && w_out_xfer) w_state_next = S_EMPTY;
        end
        S_SKID:  if (w_out_xfer) w_state_next = S_FULL;
        default: w_state_next = S_EMPTY;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (datapath enables and next handshake status)
  // -------------------------------------------------------------------------
  always_comb begin
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_clr_main_ctrl  = flush;
    if (!flush) begin
      case (r_state)
        S_EMPTY: w_load_main_in = w_in_xfer;
        S_FULL: begin
          w_load_main_in  = w_in_xfer & w_out_xfer;
          w_load_skid     = w_in_xfer & ~w_out_xfer;
          // Draining the last entry: zero the control bits so the outputs
          // read as a bubble straight from the flops.
          w_clr_main_ctrl = ~w_in_xfer & w_out_xfer;
        end
        S_SKID:  w_load_main_skid = w_out_xfer;
        default: ;
      endcase
    end

    w_in_ready_next  = (w_state_next != S_SKID);
    w_out_valid_next = (w_state_next != S_EMPTY);
    case (w_state_next)
      S_FULL:  w_occ_next = 2'd1;
      S_SKID:  w_occ_next = 2'd2;
      default: w_occ_next = 2'd0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Main entry
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_wb   <= 1'b0;
      r_main_mr   <= 1'b0;
      r_main_mw   <= 1'b0;
      r_main_dest <= '0;
      r_main_alu  <= '0;
      r_main_st   <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_wb   <= wb_en_in;
        r_main_mr   <= mem_r_en_in;
        r_main_mw   <= mem_w_en_in;
        r_main_dest <= dest_in;
        r_main_alu  <= alu_result_in;
        r_main_st   <= st_val_in;
      end else if (w_load_main_skid) begin
        r_main_wb   <= r_skid_wb;
        r_main_mr   <= r_skid_mr;
        r_main_mw   <= r_skid_mw;
        r_main_dest <= r_skid_dest;
        r_main_alu  <= r_skid_alu;
        r_main_st   <= r_skid_st;
      end
      if (w_clr_main_ctrl) begin
        r_main_wb <= 1'b0;
        r_main_mr <= 1'b0;
        r_main_mw <= 1'b0;
      end
      // Data fields are left stale on a flush; only dest is scrubbed.
      if (flush) r_main_dest <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Skid entry
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skid_wb   <= 1'b0;
      r_skid_mr   <= 1'b0;
      r_skid_mw   <= 1'b0;
      r_skid_dest <= '0;
      r_skid_alu  <= '0;
      r_skid_st   <= '0;
    end else if (flush) begin
      r_skid_wb   <= 1'b0;
      r_skid_mr   <= 1'b0;
      r_skid_mw   <= 1'b0;
      r_skid_dest <= '0;
    end else if (w_load_skid) begin
      r_skid_wb   <= wb_en_in;
      r_skid_mr   <= mem_r_en_in;
      r_skid_mw   <= mem_w_en_in;
      r_skid_dest <= dest_in;
      r_skid_alu  <= alu_result_in;
      r_skid_st   <= st_val_in;
    end
  end

`ifdef PIPE_STAT_EN
  // -------------------------------------------------------------------------
  // Saturating back-pressure counter; flush deliberately leaves it alone.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign occupancy      = r_occ;
  assign wb_en_out      = r_main_wb;
  assign mem_r_en_out   = r_main_mr;
  assign mem_w_en_out   = r_main_mw;
  assign dest_out       = r_main_dest;
  assign alu_result_out = r_main_alu;
  assign st_val_out     = r_main_st;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
module tb_ex_mem_skid_reg;

  localparam int DATA_W = 32;
  localparam int DEST_W = 4;
`ifdef PIPE_STAT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif
  localparam int STALL_MAX = (1 << CNT_W) - 1;
  localparam int PW = 3 + DEST_W + 2 * DATA_W;

  typedef struct packed {
    logic              wb;
    logic              mr;
    logic              mw;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] st;
  } ent_t;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              wb_en_in;
  logic              mem_r_en_in;
  logic              mem_w_en_in;
  logic [DEST_W-1:0] dest_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] st_val_in;
  logic              out_valid;
  logic              out_ready;
  logic              wb_en_out;
  logic              mem_r_en_out;
  logic              mem_w_en_out;
  logic [DEST_W-1:0] dest_out;
  logic [DATA_W-1:0] alu_result_out;
  logic [DATA_W-1:0] st_val_out;
  logic [1:0]        occupancy;
`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: an ordered list of held instructions, at most two deep.
  ent_t mq[$];
  int   m_stall = 0;

  ex_mem_skid_reg #(
    .DATA_W(DATA_W),
    .DEST_W(DEST_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .wb_en_in      (wb_en_in),
    .mem_r_en_in   (mem_r_en_in),
    .mem_w_en_in   (mem_w_en_in),
    .dest_in       (dest_in),
    .alu_result_in (alu_result_in),
    .st_val_in     (st_val_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .wb_en_out     (wb_en_out),
    .mem_r_en_out  (mem_r_en_out),
    .mem_w_en_out  (mem_w_en_out),
    .dest_out      (dest_out),
    .alu_result_out(alu_result_out),
    .st_val_out    (st_val_out),
    .occupancy     (occupancy)
`ifdef PIPE_STAT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic v, input logic wb, input logic mr, input logic mw,
                        input logic [DEST_W-1:0] d, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] s);
    in_valid      = v;
    wb_en_in      = wb;
    mem_r_en_in   = mr;
    mem_w_en_in   = mw;
    dest_in       = d;
    alu_result_in = a;
    st_val_in     = s;
  endtask

  // One clock: the model decides from pre-edge inputs, then the edge, then
  // sampling happens 1 time unit later.
  task automatic cycle();
    bit   acc_in;
    bit   acc_out;
    ent_t e;
    acc_in  = in_valid && (mq.size() < 2);
    acc_out = out_ready && (mq.size() > 0);
    e.wb   = wb_en_in;
    e.mr   = mem_r_en_in;
    e.mw   = mem_w_en_in;
    e.dest = dest_in;
    e.alu  = alu_result_in;
    e.st   = st_val_in;
    if (!rst) m_stall = 0;
    else if (mq.size() > 0 && !out_ready && m_stall < STALL_MAX) m_stall++;
    @(posedge clk);
    if (!rst || flush) begin
      mq.delete();
    end else begin
      if (acc_out) void'(mq.pop_front());
      if (acc_in) mq.push_back(e);
    end
    #1;
  endtask

  task automatic async_reset_pulse();
    #2;
    rst = 1'b0;
    mq.delete();
    m_stall = 0;
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) cycle();
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
    n_tests++;
    if ({wb_en_out, mem_r_en_out, mem_w_en_out, dest_out, alu_result_out, st_val_out, occupancy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ctrl=%b dest=%0h alu=%0h st=%0h occ=%0d want all 0",
               {wb_en_out, mem_r_en_out, mem_w_en_out}, dest_out, alu_result_out, st_val_out, occupancy);
    end
`ifdef PIPE_STAT_EN
    n_tests++;
    if (stall_cnt !== '0) begin
      n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
`endif
    $display("[TB] test_reset done");
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, DEST_W'(i), DATA_W'(i * 16), $urandom);
      cycle();
      n_tests++;
      if ({out_valid, dest_out, alu_result_out, occupancy} !== {1'b1, DEST_W'(i), DATA_W'(i * 16), 2'd1}) begin
        n_fail++;
        $display("FAIL stream_item%0d: got v=%0b dest=%0d alu=%0h occ=%0d want v=1 dest=%0d alu=%0h occ=1",
                 i, out_valid, dest_out, alu_result_out, occupancy, i, i * 16);
      end
    end
    in_valid = 1'b0;
    cycle();
    n_tests++;
    if (out_valid !== 1'b0 || wb_en_out !== 1'b0) begin
      n_fail++; $display("FAIL stream_drain: got v=%0b wb=%0b want 0 0", out_valid, wb_en_out);
    end
    $display("[TB] test_stream done");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 32'hA0, 32'h0);
    cycle();
    n_tests++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_after_A: got occ=%0d rdy=%0b want 1 1", occupancy, in_ready);
    end
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 32'hB0, 32'h0);
    cycle();
    n_tests++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_after_B: got occ=%0d rdy=%0b want 2 0", occupancy, in_ready);
    end
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 32'hC0, 32'h0);
    cycle();
    n_tests++;
    if (occupancy !== 2'd2 || dest_out !== 4'd5) begin
      n_fail++; $display("FAIL bp_C_ignored: got occ=%0d dest=%0d want 2 5", occupancy, dest_out);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    n_tests++;
    if (dest_out !== 4'd6 || alu_result_out !== 32'hB0 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_A_left: got dest=%0d alu=%0h rdy=%0b occ=%0d want 6 b0 1 1",
               dest_out, alu_result_out, in_ready, occupancy);
    end
    cycle();
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++; $display("FAIL bp_B_left: got v=%0b occ=%0d want 0 0 (C must not appear, dest=%0d)",
                         out_valid, occupancy, dest_out);
    end
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 4'd10, 32'h100, 32'h1);
    cycle();
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd11, 32'h110, 32'h2);
    cycle();
    n_tests++;
    if (occupancy !== 2'd2) begin
      n_fail++; $display("FAIL flush_setup_occ: got %0d want 2", occupancy);
    end
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 32'h900, 32'h9);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    n_tests++;
    if ({out_valid, occupancy, in_ready, wb_en_out, mem_r_en_out, mem_w_en_out, dest_out} !==
        {1'b0, 2'd0, 1'b1, 3'b000, DEST_W'(0)}) begin
      n_fail++;
      $display("FAIL flush_state: got v=%0b occ=%0d rdy=%0b ctrl=%b dest=%0d want 0 0 1 000 0",
               out_valid, occupancy, in_ready, {wb_en_out, mem_r_en_out, mem_w_en_out}, dest_out);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if (out_valid !== 1'b0 || dest_out === 4'd9) begin
        n_fail++; $display("FAIL flush_after%0d: got v=%0b dest=%0d want v=0 and dest!=9", i, out_valid, dest_out);
      end
    end
    $display("[TB] test_flush done");
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd12, 32'h120, 32'h12);
    cycle();
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 4'd13, 32'h130, 32'h13);
    cycle();
    in_valid = 1'b0;
    n_tests++;
    if (occupancy !== 2'd2) begin
      n_fail++; $display("FAIL areset_setup_occ: got %0d want 2", occupancy);
    end
    #2;
    rst = 1'b0;
    mq.delete();
    m_stall = 0;
    #1;
    n_tests++;
    if ({out_valid, occupancy, in_ready, wb_en_out, mem_r_en_out, mem_w_en_out, dest_out, alu_result_out, st_val_out} !==
        {1'b0, 2'd0, 1'b1, {(PW){1'b0}}}) begin
      n_fail++;
      $display("FAIL areset_immediate: got v=%0b occ=%0d rdy=%0b ctrl=%b dest=%0d alu=%0h st=%0h want 0 0 1 all-zero",
               out_valid, occupancy, in_ready, {wb_en_out, mem_r_en_out, mem_w_en_out}, dest_out,
               alu_result_out, st_val_out);
    end
    cycle();
    #2;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
        n_fail++; $display("FAIL areset_no_stale%0d: got v=%0b occ=%0d dest=%0d want 0 0", i, out_valid, occupancy, dest_out);
      end
    end
    $display("[TB] test_async_reset done");
  endtask

  task automatic test_hold();
    int n_mw;
    out_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'hAAAA, 32'h5555);
    cycle();
    for (int i = 0; i < 5; i++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, DEST_W'($urandom), $urandom, $urandom);
      cycle();
      n_tests++;
      if ({out_valid, wb_en_out, mem_r_en_out, mem_w_en_out, dest_out, alu_result_out, st_val_out} !==
          {1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'hAAAA, 32'h5555}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got v=%0b ctrl=%b dest=%0d alu=%0h st=%0h want 1 101 3 aaaa 5555",
                 i, out_valid, {wb_en_out, mem_r_en_out, mem_w_en_out}, dest_out, alu_result_out, st_val_out);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_mw = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid && mem_w_en_out) n_mw++;
      cycle();
    end
    n_tests++;
    if (n_mw !== 1) begin
      n_fail++; $display("FAIL hold_single_store: got %0d store transfers want 1", n_mw);
    end
    $display("[TB] test_hold done");
  endtask

`ifdef PIPE_STAT_EN
  task automatic test_stall_cnt();
    int exp_cnt[6] = '{1, 2, 3, 3, 3, 3};
    async_reset_pulse();
    out_ready = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h1, 32'h1);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_tests++;
      if (stall_cnt !== CNT_W'(exp_cnt[i])) begin
        n_fail++; $display("FAIL stall_cnt_step%0d: got %0d want %0d", i, stall_cnt, exp_cnt[i]);
      end
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    n_tests++;
    if (stall_cnt !== CNT_W'(3)) begin
      n_fail++; $display("FAIL stall_cnt_flush: got %0d want 3", stall_cnt);
    end
    async_reset_pulse();
    n_tests++;
    if (stall_cnt !== '0) begin
      n_fail++; $display("FAIL stall_cnt_reset: got %0d want 0", stall_cnt);
    end
    $display("[TB] test_stall_cnt done");
  endtask
`endif

  task automatic test_random();
    ent_t e;
    int   n_in;
    int   n_out;
    n_in = 0;
    n_out = 0;
    for (int c = 0; c < 400; c++) begin
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
             DEST_W'($urandom), $urandom, $urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      if (in_valid && in_ready && !flush) n_in++;
      if (out_valid && out_ready && !flush) n_out++;
      cycle();
      flush = 1'b0;
      n_tests++;
      if (mq.size() > 0) begin
        e = mq[0];
        if ({out_valid, wb_en_out, mem_r_en_out, mem_w_en_out, dest_out, alu_result_out, st_val_out} !== {1'b1, e}) begin
          n_fail++;
          $display("FAIL rand_out c%0d: got v=%0b ctrl=%b dest=%0d alu=%0h st=%0h want v=1 ctrl=%b dest=%0d alu=%0h st=%0h",
                   c, out_valid, {wb_en_out, mem_r_en_out, mem_w_en_out}, dest_out, alu_result_out, st_val_out,
                   {e.wb, e.mr, e.mw}, e.dest, e.alu, e.st);
        end
      end else begin
        if ({out_valid, wb_en_out, mem_r_en_out, mem_w_en_out} !== 4'b0000) begin
          n_fail++;
          $display("FAIL rand_bubble c%0d: got v=%0b ctrl=%b want 0 000", c, out_valid,
                   {wb_en_out, mem_r_en_out, mem_w_en_out});
        end
      end
      n_tests++;
      if (occupancy !== 2'(mq.size()) || in_ready !== (mq.size() < 2)) begin
        n_fail++;
        $display("FAIL rand_status c%0d: got occ=%0d rdy=%0b want occ=%0d rdy=%0b",
                 c, occupancy, in_ready, mq.size(), (mq.size() < 2));
      end
`ifdef PIPE_STAT_EN
      n_tests++;
      if (stall_cnt !== CNT_W'(m_stall)) begin
        n_fail++; $display("FAIL rand_stall c%0d: got %0d want %0d", c, stall_cnt, m_stall);
      end
`endif
    end
    $display("[TB] test_random done: %0d accepted, %0d delivered", n_in, n_out);
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_hold();
`ifdef PIPE_STAT_EN
    test_stall_cnt();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- Parametrised successor to the fixed EX->MEM pipeline register.
- Carries the EX results (wb/mem enables, destination, ALU result, store value) to MEM through a 2-entry skid buffer with a valid/ready handshake, so MEM back-pressure never drops an instruction.
- Adds a flush input for branch squash.
- Sits between the EX stage and the MEM stage.

Parameters:
- DATA_W, 32, width of alu_result and st_val.
- DEST_W, 4, width of destination register index.
- CNT_W, 16, width of the stall counter (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  EX presents a valid instruction.
- in_ready  out  1  buffer can accept; registered.
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control bits from EX.
- dest_in  in  DEST_W  destination register.
- alu_result_in  in  DATA_W  ALU result / address.
- st_val_in  in  DATA_W  store data.
- out_valid  out  1  MEM side holds a valid instruction.
- out_ready  in  1  MEM accepts this cycle.
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  control bits, forced 0 when out_valid=0.
- dest_out  out  DEST_W.
- alu_result_out, st_val_out  out  DATA_W.
- occupancy  out  2  entries held (0..2).
- stall_cnt  out  CNT_W  present only with PIPE_STAT_EN.

Behaviour:
- Storage: main entry (drives outputs) and skid entry. Each entry holds {wb,mr,mw,dest,alu,st}. All outputs are driven straight from main-entry flops; no combinational path from in_* to out_*.
- Reset (rst=0, async): state=EMPTY. Both entries cleared to 0. in_ready=1, out_valid=0, all out_* = 0, occupancy=0, stall_cnt=0.
- Handshake rules:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - in_ready = (state != SKID), registered.
- States and transitions:
  - EMPTY: in xfer -> load main, go FULL. Otherwise stay.
  - FULL:
    - in & out -> load main from input, stay FULL.
    - in only -> load skid, go SKID, in_ready falls next cycle.
    - out only -> go EMPTY.
    - neither -> hold.
  - SKID (in_ready=0):
    - out xfer -> main<=skid, go FULL, in_ready rises next cycle.
    - Otherwise hold.
- Latency: 1 cycle from accepted input to out_valid when the buffer is empty. Full throughput of 1/cycle while out_ready=1.
- Order: strictly FIFO. The skid entry always drains into main before any new input.
- Flush:
  - Next state EMPTY, in_ready=1, control bits and dest of both entries cleared.
  - Data fields may hold stale values.
  - Flush has priority over a simultaneous in or out transfer; a same-cycle input is discarded.
- Held outputs: main-entry fields do not change while out_valid=1 and out_ready=0.
- in_valid while in_ready=0: ignored; the payload is not captured.
- occupancy: EMPTY=0, FULL=1, SKID=2.
- Reset mid-operation: all held entries are lost immediately (async). No transfer is reported in the reset cycle.

Optional Feature:
- Macro: PIPE_STAT_EN.
- Defined:
  - stall_cnt increments every cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared by reset only; flush does not clear it.
- Undefined: the stall_cnt port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then streaming: hold rst=0 3 cycles, release; check out_valid=0, out_* = 0, in_ready=1. Then drive 4 back-to-back inputs with dest=1..4, alu_result=0x10..0x40, out_ready=1; expect outputs in order, each 1 cycle after acceptance, occupancy=1.
- Back-pressure: out_ready=0, push A (dest=5) then B (dest=6). Expect:
  - occupancy 1 then 2.
  - in_ready=0 after B.
  - C offered while in_ready=0 is not captured.
  - Raise out_ready: A then B out, in_ready=1 one cycle after A leaves.
- Flush in SKID state with simultaneous in_valid (dest=9): next cycle out_valid=0, occupancy=0, in_ready=1, wb/mr/mw_out=0. dest=9 never appears.
- Async reset mid-stream: drop rst between clock edges while occupancy=2. Outputs clear immediately without a clock edge, and no stale entry emerges after release.
- Hold stability: out_valid=1, out_ready=0 for 5 cycles with in_* toggling; out_* remain constant and mem_w_en_out stays asserted only once.
- PIPE_STAT_EN with CNT_W=2: stall 6 cycles; stall_cnt reads 1,2,3,3,3,3. A flush leaves it at 3; reset clears it to 0.
